// File: rtl/mem_access_ctrl.sv
// mem_access_ctrl: MEM-stage initiator for a byte-addressed big-endian data memory.
// Issues single-beat loads/stores and two-beat LDD/STD, checks alignment, extends
// sub-word loads and registers load results for the MEM/WB register.
// Optional LDSTUB atomic sequencing is enabled by defining the macro LDSTUB_EN.
module mem_access_ctrl #(
    parameter int unsigned ADDR_W = 9,
    parameter int unsigned DATA_W = 32
) (
    input  logic              clk,
    input  logic              R,
    input  logic              req_valid,
    input  logic              req_load,
    input  logic              req_store,
    input  logic [1:0]        req_size,
    input  logic              req_signed,
    input  logic [31:0]       req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    input  logic [DATA_W-1:0] req_wdata2,
    output logic [ADDR_W-1:0] mem_A,
    output logic [DATA_W-1:0] mem_DI,
    output logic [1:0]        mem_Size,
    output logic              mem_RW,
    output logic              mem_E,
    input  logic [DATA_W-1:0] mem_DO,
    output logic [DATA_W-1:0] ld_data,
    output logic [DATA_W-1:0] ld_data2,
    output logic              ld_valid,
    output logic              misalign_trap,
    output logic              stall
);

`ifdef LDSTUB_EN
    typedef enum logic [1:0] {S_IDLE = 2'd0, S_DBL2 = 2'd1, S_ATOM_WR = 2'd2} state_t;
`else
    typedef enum logic [1:0] {S_IDLE = 2'd0, S_DBL2 = 2'd1} state_t;
`endif

    state_t            r_state;
    logic [ADDR_W-1:0] r_addr2;
    logic [DATA_W-1:0] r_wdata2;
    logic              r_is_load;
    logic [DATA_W-1:0] r_ld_data;
    logic [DATA_W-1:0] r_ld_data2;
    logic              r_ld_valid;
    logic              r_trap;

    logic              w_ld_only;
    logic              w_st_only;
    logic              w_aligned;
    logic              w_go;
    logic              w_dbl;
    logic              w_trap;
    logic [DATA_W-1:0] w_ext;
    logic              w_unused_addr;
`ifdef LDSTUB_EN
    logic              w_atom;
`endif

    // Request decode: exactly one of load/store makes a normal access.
    assign w_ld_only     = req_valid & req_load & ~req_store;
    assign w_st_only     = req_valid & req_store & ~req_load;
    assign w_go          = (w_ld_only | w_st_only) & w_aligned;
    assign w_dbl         = w_go & (req_size == 2'b11);
    assign w_trap        = (w_ld_only | w_st_only) & ~w_aligned;
    assign w_unused_addr = ^req_addr[31:ADDR_W];
`ifdef LDSTUB_EN
    assign w_atom        = req_valid & req_load & req_store & (req_size == 2'b00);
`endif

    // Natural alignment check by access size.
    always_comb begin
        w_aligned = 1'b0;
        case (req_size)
            2'b00:   w_aligned = 1'b1;
            2'b01:   w_aligned = ~req_addr[0];
            2'b10:   w_aligned = (req_addr[1:0] == 2'b00);
            default: w_aligned = (req_addr[2:0] == 3'b000);
        endcase
    end

    // Sign/zero extension of the right-justified memory read data.
    always_comb begin
        w_ext = mem_DO;
        case (req_size)
            2'b00:   w_ext = {{(DATA_W-8){req_signed & mem_DO[7]}}, mem_DO[7:0]};
            2'b01:   w_ext = {{(DATA_W-16){req_signed & mem_DO[15]}}, mem_DO[15:0]};
            default: w_ext = mem_DO;
        endcase
    end

    // Memory-side drive and stall; idle values whenever reset or no access.
    always_comb begin
        mem_A    = '0;
        mem_DI   = '0;
        mem_Size = 2'b10;
        mem_RW   = 1'b0;
        mem_E    = 1'b0;
        stall    = 1'b0;
        if (R) begin
            case (r_state)
                S_IDLE: begin
                    if (w_go) begin
                        mem_A    = req_addr[ADDR_W-1:0];
                        mem_Size = w_dbl ? 2'b10 : req_size;
                        stall    = w_dbl;
                        if (w_st_only) begin
                            mem_RW = 1'b1;
                            mem_E  = 1'b1;
                            mem_DI = req_wdata;
                        end
                    end
`ifdef LDSTUB_EN
                    else if (w_atom) begin
                        mem_A    = req_addr[ADDR_W-1:0];
                        mem_Size = 2'b00;
                        stall    = 1'b1;
                    end
`endif
                end
                S_DBL2: begin
                    mem_A    = r_addr2;
                    mem_Size = 2'b10;
                    if (!r_is_load) begin
                        mem_RW = 1'b1;
                        mem_E  = 1'b1;
                        mem_DI = r_wdata2;
                    end
                end
`ifdef LDSTUB_EN
                S_ATOM_WR: begin
                    mem_A    = r_addr2;
                    mem_Size = 2'b00;
                    mem_DI   = DATA_W'(8'hFF);
                    mem_RW   = 1'b1;
                    mem_E    = 1'b1;
                end
`endif
                default: ;
            endcase
        end
    end

    // Sequencer: state, second-beat latches and registered load results/pulses.
    always_ff @(posedge clk or negedge R) begin
        if (!R) begin
            r_state    <= S_IDLE;
            r_addr2    <= '0;
            r_wdata2   <= '0;
            r_is_load  <= 1'b0;
            r_ld_data  <= '0;
            r_ld_data2 <= '0;
            r_ld_valid <= 1'b0;
            r_trap     <= 1'b0;
        end else begin
            r_ld_valid <= 1'b0;
            r_trap     <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (w_go) begin
                        if (w_ld_only) begin
                            r_ld_data <= w_ext;
                        end
                        if (w_dbl) begin
                            r_addr2   <= req_addr[ADDR_W-1:0] + ADDR_W'(4);
                            r_wdata2  <= req_wdata2;
                            r_is_load <= w_ld_only;
                            r_state   <= S_DBL2;
                        end else begin
                            r_ld_valid <= w_ld_only;
                        end
                    end else if (w_trap) begin
                        r_trap <= 1'b1;
                    end
`ifdef LDSTUB_EN
                    else if (w_atom) begin
                        r_ld_data <= DATA_W'(mem_DO[7:0]);
                        r_addr2   <= req_addr[ADDR_W-1:0];
                        r_state   <= S_ATOM_WR;
                    end
`endif
                end
                S_DBL2: begin
                    if (r_is_load) begin
                        r_ld_data2 <= mem_DO;
                        r_ld_valid <= 1'b1;
                    end
                    r_state <= S_IDLE;
                end
`ifdef LDSTUB_EN
                S_ATOM_WR: begin
                    r_ld_valid <= 1'b1;
                    r_state    <= S_IDLE;
                end
`endif
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign ld_data       = r_ld_data;
    assign ld_data2      = r_ld_data2;
    assign ld_valid      = r_ld_valid;
    assign misalign_trap = r_trap;

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Testbench for mem_access_ctrl: big-endian byte memory device plus a byte-array
// reference model; directed scenarios followed by randomized requests.
module tb_mem_access_ctrl;

    localparam int K_NONE = 0;
    localparam int K_TRAP = 1;
    localparam int K_LD   = 2;
    localparam int K_ST   = 3;
    localparam int K_LDD  = 4;
    localparam int K_STD  = 5;
    localparam int K_ATOM = 6;
`ifdef LDSTUB_EN
    localparam bit LDSTUB_ON = 1'b1;
`else
    localparam bit LDSTUB_ON = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        R;
    logic        req_valid, req_load, req_store, req_signed;
    logic [1:0]  req_size;
    logic [31:0] req_addr, req_wdata, req_wdata2;
    logic [8:0]  mem_A;
    logic [31:0] mem_DI, mem_DO;
    logic [1:0]  mem_Size;
    logic        mem_RW, mem_E;
    logic [31:0] ld_data, ld_data2;
    logic        ld_valid, misalign_trap, stall;

    logic [7:0]  dev_mem [512];
    logic [7:0]  ref_mem [512];
    logic        fill_en;
    logic [8:0]  a1, a2, a3;

    logic [31:0] exp_ld, exp_ld2;
    int          n_checks = 0;
    int          n_err    = 0;

    mem_access_ctrl dut (
        .clk(clk), .R(R),
        .req_valid(req_valid), .req_load(req_load), .req_store(req_store),
        .req_size(req_size), .req_signed(req_signed), .req_addr(req_addr),
        .req_wdata(req_wdata), .req_wdata2(req_wdata2),
        .mem_A(mem_A), .mem_DI(mem_DI), .mem_Size(mem_Size), .mem_RW(mem_RW),
        .mem_E(mem_E), .mem_DO(mem_DO),
        .ld_data(ld_data), .ld_data2(ld_data2), .ld_valid(ld_valid),
        .misalign_trap(misalign_trap), .stall(stall)
    );

    always #5 clk = ~clk;

    // Memory device: combinational big-endian read, right-justified.
    assign a1 = mem_A + 9'd1;
    assign a2 = mem_A + 9'd2;
    assign a3 = mem_A + 9'd3;
    always_comb begin
        case (mem_Size)
            2'b00:   mem_DO = {24'h0, dev_mem[mem_A]};
            2'b01:   mem_DO = {16'h0, dev_mem[mem_A], dev_mem[a1]};
            default: mem_DO = {dev_mem[mem_A], dev_mem[a1], dev_mem[a2], dev_mem[a3]};
        endcase
    end

    // Memory device: synchronous write, plus a one-shot preload from the model image.
    always @(posedge clk) begin
        if (fill_en) begin
            for (int i = 0; i < 512; i++) dev_mem[i] <= ref_mem[i];
        end else if (mem_E) begin
            case (mem_Size)
                2'b00: dev_mem[mem_A] <= mem_DI[7:0];
                2'b01: begin
                    dev_mem[mem_A] <= mem_DI[15:8];
                    dev_mem[a1]    <= mem_DI[7:0];
                end
                default: begin
                    dev_mem[mem_A] <= mem_DI[31:24];
                    dev_mem[a1]    <= mem_DI[23:16];
                    dev_mem[a2]    <= mem_DI[15:8];
                    dev_mem[a3]    <= mem_DI[7:0];
                end
            endcase
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] ref_rd(input int a, input int n);
        logic [31:0] v = 32'h0;
        for (int i = 0; i < n; i++) v = (v << 8) | 32'(ref_mem[(a + i) % 512]);
        return v;
    endfunction

    task automatic ref_wr(input int a, input int n, input logic [31:0] v);
        for (int i = 0; i < n; i++) ref_mem[(a + i) % 512] = 8'(v >> (8 * (n - 1 - i)));
    endtask

    task automatic drive_idle();
        req_valid = 1'b0; req_load = 1'b0; req_store = 1'b0; req_signed = 1'b0;
        req_size = 2'b00; req_addr = 32'h0; req_wdata = 32'h0; req_wdata2 = 32'h0;
    endtask

    // One request through the DUT; expectations come from the byte-array model.
    task automatic do_req(input logic ld, input logic st, input logic [1:0] sz, input logic sg,
                          input logic [31:0] addr, input logic [31:0] wd, input logic [31:0] wd2);
        int a, nb, kind;
        bit aligned, two_beat;
        logic [31:0] v;
        a = int'(addr[8:0]);
        nb = (sz == 2'd0) ? 1 : (sz == 2'd1) ? 2 : 4;
        aligned = (addr % (32'd1 << sz)) == 32'd0;
        if (ld ^ st) kind = !aligned ? K_TRAP : (sz == 2'd3) ? (ld ? K_LDD : K_STD) : (ld ? K_LD : K_ST);
        else if (ld && st && sz == 2'd0 && LDSTUB_ON) kind = K_ATOM;
        else kind = K_NONE;
        two_beat = (kind == K_LDD || kind == K_STD || kind == K_ATOM);
        case (kind)
            K_LD: begin
                v = ref_rd(a, nb);
                if (sg && sz == 2'd0 && v[7])  v = v | 32'hFFFFFF00;
                if (sg && sz == 2'd1 && v[15]) v = v | 32'hFFFF0000;
                exp_ld = v;
            end
            K_ST:  ref_wr(a, nb, wd);
            K_LDD: begin exp_ld = ref_rd(a, 4); exp_ld2 = ref_rd(a + 4, 4); end
            K_STD: begin ref_wr(a, 4, wd); ref_wr(a + 4, 4, wd2); end
            K_ATOM: begin exp_ld = ref_rd(a, 1); ref_wr(a, 1, 32'hFF); end
            default: ;
        endcase

        req_valid = 1'b1; req_load = ld; req_store = st; req_size = sz; req_signed = sg;
        req_addr = addr; req_wdata = wd; req_wdata2 = wd2;
        #1;
        chk("stall_beat1", 32'(stall), 32'(two_beat));
        chk("mem_E_beat1", 32'(mem_E), 32'(kind == K_ST || kind == K_STD));
        if (kind >= K_LD) begin
            chk("mem_A_beat1", 32'(mem_A), 32'(a));
            chk("mem_Size_beat1", 32'(mem_Size),
                (kind == K_ATOM) ? 32'd0 : two_beat ? 32'd2 : 32'(sz));
            chk("mem_RW_beat1", 32'(mem_RW), 32'(kind == K_ST || kind == K_STD));
        end
        if (kind == K_ST || kind == K_STD) chk("mem_DI_beat1", mem_DI, wd);
        @(posedge clk); #1;
        if (two_beat) begin
            // Junk request during the second beat must be ignored.
            req_valid = 1'b1; req_load = 1'b1; req_store = 1'b0; req_size = 2'b10;
            req_addr = $urandom & 32'hFFFF_FFFC; req_wdata = $urandom;
            #1;
            chk("stall_beat2", 32'(stall), 32'd0);
            chk("mem_A_beat2", 32'(mem_A), (kind == K_ATOM) ? 32'(a) : 32'((a + 4) % 512));
            chk("mem_E_beat2", 32'(mem_E), 32'(kind != K_LDD));
            if (kind == K_STD)  chk("mem_DI_beat2", mem_DI, wd2);
            if (kind == K_ATOM) chk("mem_DI_atom", mem_DI, 32'hFF);
            chk("ld_valid_beat2", 32'(ld_valid), 32'd0);
            @(posedge clk); #1;
        end
        drive_idle();
        #1;
        chk("mem_E_idle", 32'(mem_E), 32'd0);
        chk("ld_valid", 32'(ld_valid), 32'(kind == K_LD || kind == K_LDD || kind == K_ATOM));
        chk("misalign_trap", 32'(misalign_trap), 32'(kind == K_TRAP));
        chk("ld_data", ld_data, exp_ld);
        chk("ld_data2", ld_data2, exp_ld2);
        @(posedge clk); #1;
        chk("ld_valid_pulse_end", 32'(ld_valid), 32'd0);
        chk("trap_pulse_end", 32'(misalign_trap), 32'd0);
    endtask

    initial begin
        logic [1:0]  sz;
        logic [31:0] addr;
        int          r;
        exp_ld = 32'h0; exp_ld2 = 32'h0;
        for (int i = 0; i < 512; i++) ref_mem[i] = 8'($urandom);
        drive_idle();
        R = 1'b0; fill_en = 1'b1;
        @(posedge clk); #1;
        fill_en = 1'b0;
        // Outputs must stay idle in reset even with a request present.
        req_valid = 1'b1; req_store = 1'b1; req_size = 2'b10; req_addr = 32'h10; req_wdata = 32'h1234;
        #1;
        chk("rst_mem_E", 32'(mem_E), 32'd0);
        chk("rst_mem_RW", 32'(mem_RW), 32'd0);
        chk("rst_mem_Size", 32'(mem_Size), 32'd2);
        chk("rst_mem_A", 32'(mem_A), 32'd0);
        chk("rst_mem_DI", mem_DI, 32'd0);
        chk("rst_stall", 32'(stall), 32'd0);
        chk("rst_ld_data", ld_data, 32'd0);
        chk("rst_ld_data2", ld_data2, 32'd0);
        chk("rst_ld_valid", 32'(ld_valid), 32'd0);
        chk("rst_trap", 32'(misalign_trap), 32'd0);
        drive_idle();
        #3; R = 1'b1;
        @(posedge clk); #1;

        // Word store then sub-word loads with extension.
        do_req(1'b0, 1'b1, 2'b10, 1'b0, 32'h010, 32'hDEADBEEF, 32'h0);
        do_req(1'b1, 1'b0, 2'b00, 1'b1, 32'h010, 32'h0, 32'h0);
        chk("plan_signed_byte", ld_data, 32'hFFFFFFDE);
        do_req(1'b1, 1'b0, 2'b01, 1'b0, 32'h012, 32'h0, 32'h0);
        chk("plan_unsigned_half", ld_data, 32'h0000BEEF);

        // Misaligned half load and misaligned store.
        do_req(1'b1, 1'b0, 2'b01, 1'b1, 32'h011, 32'h0, 32'h0);
        do_req(1'b0, 1'b1, 2'b10, 1'b0, 32'h012, 32'hCAFEF00D, 32'h0);

        // STD then LDD.
        do_req(1'b0, 1'b1, 2'b11, 1'b0, 32'h020, 32'h11111111, 32'h22222222);
        do_req(1'b1, 1'b0, 2'b11, 1'b0, 32'h020, 32'h0, 32'h0);
        chk("plan_ldd_w0", ld_data, 32'h11111111);
        chk("plan_ldd_w1", ld_data2, 32'h22222222);

        // Top-of-memory double, misaligned double, upper address bits ignored.
        do_req(1'b1, 1'b0, 2'b11, 1'b0, 32'h1F8, 32'h0, 32'h0);
        do_req(1'b1, 1'b0, 2'b11, 1'b0, 32'h1FC, 32'h0, 32'h0);
        do_req(1'b1, 1'b0, 2'b10, 1'b0, 32'hB4B4_B5FC, 32'h0, 32'h0);
        chk("plan_upper_addr", ld_data, ref_rd(32'h1FC, 4));
        do_req(1'b0, 1'b1, 2'b11, 1'b0, 32'h1F8, 32'hA5A5A5A5, 32'h5A5A5A5A);

        // Reset asserted during the second beat of an STD.
        req_valid = 1'b1; req_load = 1'b0; req_store = 1'b1; req_size = 2'b11;
        req_addr = 32'h040; req_wdata = 32'h33445566; req_wdata2 = 32'h778899AA;
        #1;
        chk("rst_std_stall", 32'(stall), 32'd1);
        ref_wr(32'h040, 4, 32'h33445566);
        @(posedge clk); #1;
        drive_idle();
        R = 1'b0;
        #1;
        chk("rst_dbl2_mem_E", 32'(mem_E), 32'd0);
        chk("rst_dbl2_mem_A", 32'(mem_A), 32'd0);
        chk("rst_dbl2_stall", 32'(stall), 32'd0);
        chk("rst_dbl2_ld_data", ld_data, 32'd0);
        chk("rst_dbl2_ld_data2", ld_data2, 32'd0);
        exp_ld = 32'h0; exp_ld2 = 32'h0;
        @(posedge clk); #3;
        R = 1'b1;
        @(posedge clk); #1;
        do_req(1'b1, 1'b0, 2'b10, 1'b0, 32'h044, 32'h0, 32'h0);
        do_req(1'b1, 1'b0, 2'b10, 1'b0, 32'h040, 32'h0, 32'h0);
        chk("rst_first_beat_kept", ld_data, 32'h33445566);

        // Load+store together: LDSTUB when enabled, otherwise ignored.
        do_req(1'b0, 1'b1, 2'b00, 1'b0, 32'h030, 32'h00000005, 32'h0);
        do_req(1'b1, 1'b1, 2'b00, 1'b0, 32'h030, 32'h0, 32'h0);
        do_req(1'b1, 1'b0, 2'b00, 1'b0, 32'h030, 32'h0, 32'h0);
        chk("ldstub_after", ld_data, LDSTUB_ON ? 32'h000000FF : 32'h00000005);
        do_req(1'b1, 1'b1, 2'b10, 1'b0, 32'h030, 32'h0, 32'h0);

        // Randomized requests.
        for (int i = 0; i < 200; i++) begin
            sz = 2'($urandom_range(0, 3));
            addr = $urandom;
            if ($urandom_range(0, 3) != 0) addr = addr & ~((32'd1 << sz) - 32'd1);
            r = $urandom_range(0, 9);
            do_req(r < 4 || r == 8, (r >= 4 && r < 8) || r == 8, sz, 1'($urandom),
                   addr, $urandom, $urandom);
        end

        // Final memory image against the model.
        for (int i = 0; i < 512; i++) chk("mem_image", 32'(dev_mem[i]), 32'(ref_mem[i]));

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end

endmodule

// File: doc/mem_access_ctrl.md
Name: mem_access_ctrl

Overview:
MEM-stage initiator that drives the byte-addressed big-endian data memory. Its memory-side ports are A[8:0], DI, Size, RW, E and DO; reads from that memory are combinational and writes are synchronous.
Takes load/store requests from the EX/MEM register and issues single or two-beat accesses (SPARC LDD/STD). It performs alignment checks and sign/zero extension, registers load results for the MEM/WB register, and asserts stall while a multi-cycle access is in progress.

Parameters:
ADDR_W, 9, memory address bits driven on mem_A; upper request address bits ignored.
DATA_W, 32, word width.

Ports:
clk  input  1  clock
R  input  1  asynchronous reset, active-low (0 = reset)
req_valid  input  1  request present this cycle
req_load  input  1  load request
req_store  input  1  store request
req_size  input  2  00 byte, 01 half, 10 word, 11 double
req_signed  input  1  sign-extend byte/half loads
req_addr  input  32  byte address
req_wdata  input  32  store data, first word
req_wdata2  input  32  store data, second word (STD odd register)
mem_A  output  9  memory address
mem_DI  output  32  memory write data
mem_Size  output  2  memory access size
mem_RW  output  1  0 read, 1 write
mem_E  output  1  write enable
mem_DO  input  32  memory read data (combinational)
ld_data  output  32  load result, first word
ld_data2  output  32  second word of LDD
ld_valid  output  1  one-cycle pulse: ld_data/ld_data2 valid
misalign_trap  output  1  one-cycle pulse: misaligned request dropped
stall  output  1  hold EX/MEM register and upstream stages

Behaviour:
- Reset (R=0, async): state IDLE; ld_data, ld_data2, ld_valid, misalign_trap and latched request all 0. Memory-side outputs go idle: mem_E=0, mem_RW=0, mem_Size=10, mem_A=0, mem_DI=0.
- Alignment: byte is always aligned. Half needs addr[0]=0. Word needs addr[1:0]=0. Double needs addr[2:0]=0.
- Misaligned request: no memory access and mem_E=0. misalign_trap=1 on the next cycle; ld_valid stays 0.
- req_load and req_store both set (macro off): request ignored, with no access, trap or ld_valid.
- IDLE, aligned single access (size 00/01/10): mem_* driven combinationally from req in the same cycle; mem_A=req_addr[8:0], mem_Size=req_size.
  - Store: mem_RW=1, mem_E=1, mem_DI=req_wdata; the memory writes at that edge.
  - Load: mem_RW=0, mem_E=0. At the edge ld_data gets the extended mem_DO, and ld_valid=1 on the next cycle. Latency is 1.
  - stall=0.
- Extension: byte signed replicates bit 7; half signed replicates bit 15; unsigned zero-fills. Word/double are passed unchanged.
- IDLE, aligned double: first beat uses mem_Size=10, addr=req_addr[8:0], data=req_wdata. stall=1 combinationally in this cycle.
  - At the edge: latch addr+4 (9-bit wrap mod 512) and req_wdata2. A load captures ld_data=mem_DO. Then go to DBL2.
- DBL2: second beat from the latched address/data, mem_Size=10, stall=0.
  - At the edge: a load captures ld_data2 and pulses ld_valid next cycle (total latency 2). Return to IDLE.
  - req inputs are ignored in DBL2.
- Pipeline holds req_* stable while stall=1.
- No request (req_valid=0): memory-side outputs idle as in reset; ld_valid=0.
- Reset during DBL2: abort and return to IDLE with no second beat. A first-beat store already written remains in memory.
- ld_data and ld_data2 hold their values until the next load capture.

Optional Feature:
LDSTUB_EN.
- Defined: req_load=req_store=1 with req_size=00 and aligned is atomic LDSTUB, sequenced IDLE -> ATOM_WR -> IDLE.
  - IDLE beat: byte read; stall=1; capture ld_data=zero-extended byte.
  - ATOM_WR beat: write 8'hFF to the same address with mem_RW=1, mem_E=1, stall=0; ld_valid pulses after.
  - Same load+store combination with another size: ignored.
- Undefined: state ATOM_WR absent; load+store together is always ignored.

Test Plan:
1. Store word 0xDEADBEEF at 0x010, then signed byte load at 0x010 -> ld_data=0xFFFFFFDE, ld_valid 1 cycle after the load; unsigned half at 0x012 -> 0x0000BEEF.
2. Half load at 0x011 -> mem_E=0, misalign_trap pulse, no ld_valid; memory unchanged.
3. STD at 0x020, wdata=0x11111111, wdata2=0x22222222, then LDD at 0x020 -> stall high for 1 cycle each, ld_data=0x11111111, ld_data2=0x22222222, ld_valid 2 cycles after request.
4. LDD at 0x1F8 -> second beat at 0x1FC; LDD at 0x1FC -> trap; word load at 0x1FC with req_addr[31:9]≠0 -> same data as 0x1FC.
5. STD at 0x040, R low in the DBL2 cycle -> outputs 0, state IDLE, mem[0x040..0x043] written, mem[0x044..0x047] unchanged.
6. With LDSTUB_EN: mem[0x030]=0x05, LDSTUB 0x030 -> ld_data=0x00000005, then mem[0x030]=0xFF; without the macro, no access occurs.
